mmu_arbiter: RTL and testbench
==============================

MMU_ARBITER -- requirements
Module: mmu_arbiter

Interface
REQ-001 Parameter DATA_PRIORITY, default 0; 0 = round-robin between I and D, 1 = fixed priority to D.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ireq  input  cbus_req_t  instruction-side request; valid/addr/size/data/strobe/is_write.
REQ-005 iresp  output  cbus_resp_t  instruction-side response; ready + data.
REQ-006 dreq  input  cbus_req_t  data-side request.
REQ-007 dresp  output  cbus_resp_t  data-side response.
REQ-008 mmu_req_valid  output  1  request-valid to the shared translating MMU.
REQ-009 mmu_vreq  output  cbus_req_t  virtual request presented to the MMU.
REQ-010 mmu_ok  input  1  one-cycle completion pulse from the MMU.
REQ-011 mmu_presp  input  cbus_resp_t  MMU-side response; data valid when mmu_ok=1.

Function
REQ-012 FSM states SHALL be ARB_IDLE, ARB_BUSY, ARB_RESP; one transaction is in flight at a time.
REQ-013 ARB_IDLE: if ireq.valid or dreq.valid, select winner, latch its full request into mmu_vreq, record owner, go ARB_BUSY next cycle; else stay.
REQ-014 Round-robin (DATA_PRIORITY=0): both valid -> grant the side not granted last; one valid -> grant it; last-grant updates on every grant.
REQ-015 DATA_PRIORITY=1: dreq wins whenever both are valid.
REQ-016 ARB_BUSY: mmu_req_valid=1, mmu_vreq held constant; on mmu_ok=1 latch mmu_presp.data, go ARB_RESP; else stay (no timeout).
REQ-017 ARB_RESP (exactly one cycle): mmu_req_valid=0; owner's resp.ready=1 with latched data; other side ready=0; next state ARB_IDLE.
REQ-018 mmu_req_valid SHALL be 1 only in ARB_BUSY, guaranteeing the MMU sees valid low at least one cycle between transactions.
REQ-019 Requests arriving in ARB_BUSY/ARB_RESP are not sampled; they are evaluated in ARB_IDLE only; minimum turnaround = 3 cycles (IDLE, BUSY, RESP) plus MMU latency.
REQ-020 Non-owner's request changing or dropping mid-transaction SHALL have no effect; owner drops valid after ready.
REQ-021 mmu_ok while not in ARB_BUSY SHALL be ignored (no response, no state change).
REQ-022 iresp/dresp.data outside the owner's ARB_RESP cycle SHALL be 0.

Reset
REQ-023 On reset assertion (any state, including mid-transaction): state=ARB_IDLE, mmu_req_valid=0, mmu_vreq=0, iresp=0, dresp=0, latched data=0, last-grant=D (so I wins first tie).
REQ-024 Aborted in-flight transaction SHALL NOT generate a response after reset release.

Structure
REQ-025 arb_state_t (ARB_IDLE/ARB_BUSY/ARB_RESP) and owner enum SHALL live in the shared pipes package; cbus types reused from common.
REQ-026 One sub-module rr_arbiter2 (2-way round-robin picker with last-grant register and fixed-priority override) SHALL be instantiated; rest is flat.

Verification
REQ-027 ireq.valid only, addr=0x8000_0000, MMU mmu_ok after 5 cycles with data 0x0000_0013 -> mmu_vreq.addr=0x8000_0000, iresp.ready=1 one cycle later with data 0x13, dresp.ready=0.
REQ-028 ireq and dreq valid same cycle after reset, DATA_PRIORITY=0 -> I served first, then D; repeat both valid -> order alternates I,D,I,D.
REQ-029 DATA_PRIORITY=1, both valid continuously for 4 transactions -> all 4 grants to D; I granted only after dreq.valid drops.
REQ-030 dreq write addr=0x8000_1000, data=0xDEAD_BEEF, strobe=0xFF -> mmu_vreq carries identical fields; they stay unchanged while requester alters non-owner ireq; dresp.ready one pulse after mmu_ok.
REQ-031 reset asserted in ARB_BUSY, then mmu_ok pulse after release -> all outputs 0, no ready on either side, next request served normally.
REQ-032 Check mmu_req_valid low for >=1 cycle between back-to-back transactions and never high outside ARB_BUSY.

Source files
------------

// File: rtl/mmu_arbiter_pkg.sv
// mmu_arbiter_pkg: shared cbus transaction types and arbiter state/owner encodings
package mmu_arbiter_pkg;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strobe;
        logic              is_write;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

endpackage

// File: rtl/mmu_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way I/D picker with last-grant memory and optional fixed D priority
module rr_arbiter2
    import mmu_arbiter_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       advance,
    output arb_owner_t grant
);

    arb_owner_t last_q;

    // A tie goes to D under fixed priority, otherwise to whoever was not served last
    always_comb begin
        grant = (req_i && req_d) ? ((DATA_PRIORITY || last_q == OWN_I) ? OWN_D : OWN_I)
                                 : (req_d ? OWN_D : OWN_I);
    end

    // Last grant starts at D so the first tie after reset goes to I
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_q <= OWN_D;
        else if (advance)
            last_q <= grant;
    end

endmodule

// File: rtl/mmu_arbiter.sv
// mmu_arbiter: serialises instruction and data cbus requests onto one translating MMU
module mmu_arbiter
    import mmu_arbiter_pkg::*;
#(
    parameter bit DATA_PRIORITY = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireq,
    output cbus_resp_t iresp,
    input  cbus_req_t  dreq,
    output cbus_resp_t dresp,
    output logic       mmu_req_valid,
    output cbus_req_t  mmu_vreq,
    input  logic       mmu_ok,
    input  cbus_resp_t mmu_presp
);

    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q, grant;
    logic [DATA_W-1:0] data_q;
    logic              start;
    logic              presp_unused;

    assign start        = (state_q == ARB_IDLE) && (ireq.valid || dreq.valid);
    assign presp_unused = mmu_presp.ready;

    rr_arbiter2 #(.DATA_PRIORITY(DATA_PRIORITY)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req_i   (ireq.valid),
        .req_d   (dreq.valid),
        .advance (start),
        .grant   (grant)
    );

    // Next state and outputs; responses are driven only in the owner's RESP cycle
    always_comb begin
        state_d       = (state_q == ARB_IDLE) ? (start ? ARB_BUSY : ARB_IDLE)
                      : (state_q == ARB_BUSY) ? (mmu_ok ? ARB_RESP : ARB_BUSY)
                      : ARB_IDLE;
        mmu_req_valid = (state_q == ARB_BUSY);
        iresp         = '0;
        dresp         = '0;
        if (state_q == ARB_RESP && owner_q == OWN_I)
            iresp = '{ready: 1'b1, data: data_q};
        if (state_q == ARB_RESP && owner_q == OWN_D)
            dresp = '{ready: 1'b1, data: data_q};
    end

    // State, winning request and MMU read data; reset drops any in-flight transaction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            owner_q  <= OWN_I;
            mmu_vreq <= '0;
            data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                owner_q  <= grant;
                mmu_vreq <= (grant == OWN_D) ? dreq : ireq;
            end
            if (state_q == ARB_BUSY && mmu_ok)
                data_q <= mmu_presp.data;
        end
    end

endmodule

// File: tb/tb_mmu_arbiter.sv
// tb_mmu_arbiter: scoreboard bench running round-robin and D-priority arbiters side by side
module tb_mmu_arbiter;
    import mmu_arbiter_pkg::*;

    typedef struct packed {
        logic        is_d;
        cbus_req_t   req;
        logic [63:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       mmu_ok;
    cbus_req_t  ireq, dreq;
    cbus_resp_t mmu_presp;
    cbus_resp_t ir [2];
    cbus_resp_t dr [2];
    logic       v [2];
    cbus_req_t  vr [2];
    exp_t       q [2][$];
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    mmu_arbiter #(.DATA_PRIORITY(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(ir[0]), .dreq(dreq), .dresp(dr[0]),
        .mmu_req_valid(v[0]), .mmu_vreq(vr[0]), .mmu_ok(mmu_ok), .mmu_presp(mmu_presp)
    );

    mmu_arbiter #(.DATA_PRIORITY(1'b1)) dut1 (
        .clk(clk), .reset(reset), .ireq(ireq), .iresp(ir[1]), .dreq(dreq), .dresp(dr[1]),
        .mmu_req_valid(v[1]), .mmu_vreq(vr[1]), .mmu_ok(mmu_ok), .mmu_presp(mmu_presp)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cbus_req_t mk(input logic [63:0] addr, input logic [63:0] data,
                                     input logic [7:0] strb, input logic wr);
        return '{valid: 1'b1, addr: addr, size: 3'd3, data: data, strobe: strb, is_write: wr};
    endfunction

    task automatic expect_both(input logic d0, input logic d1, input logic [63:0] data);
        q[0].push_back('{is_d: d0, req: d0 ? dreq : ireq, data: data});
        q[1].push_back('{is_d: d1, req: d1 ? dreq : ireq, data: data});
    endtask

    task automatic wait_busy(output bit ok);
        int n = 0;
        while (!v[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        ok = v[0];
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: mmu_req_valid still %0b after %0d cycles, need 1", v[0], n);
        end
        chk("valid_lockstep", 256'(v[1]), 256'(v[0]));
    endtask

    task automatic serve(input int lat, input logic [63:0] d, input bit wiggle);
        bit ok;
        wait_busy(ok);
        if (!ok) return;
        if (wiggle) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk);
                #1 ireq = mk(64'h4000_0000 + 64'(i * 8), 64'(i), 8'h0F, 1'b1);
            end
            @(posedge clk);
            #1 ireq = '0;
        end
        repeat (lat) @(posedge clk);
        #1 mmu_ok = 1'b1;
        mmu_presp = '{ready: 1'b1, data: d};
        @(posedge clk);
        #1 mmu_ok = 1'b0;
        mmu_presp = '{ready: 1'b0, data: 64'hBAD0_BAD0};
    endtask

    task automatic check_quiet(input string name);
        for (int k = 0; k < 2; k++) begin
            chk({name, "_valid"}, 256'(v[k]), 256'(0));
            chk({name, "_iresp"}, 256'(ir[k]), 256'(0));
            chk({name, "_dresp"}, 256'(dr[k]), 256'(0));
        end
    endtask

    // Monitor: pops one expectation per ready pulse and checks idle-time invariants
    initial begin
        cbus_req_t cap [2];
        logic      vprev [2];
        exp_t      e;
        logic      rdy;
        cap   = '{'0, '0};
        vprev = '{1'b0, 1'b0};
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                rdy = ir[k].ready | dr[k].ready;
                if (!ir[k].ready) chk($sformatf("iresp%0d_data_idle", k), 256'(ir[k].data), 256'(0));
                if (!dr[k].ready) chk($sformatf("dresp%0d_data_idle", k), 256'(dr[k].data), 256'(0));
                if (v[k] && vprev[k]) chk($sformatf("vreq%0d_stable", k), 256'(vr[k]), 256'(cap[k]));
                if (v[k]) cap[k] = vr[k];
                if (rdy) begin
                    chk($sformatf("valid%0d_low_in_resp", k), 256'(v[k]), 256'(0));
                    if (q[k].size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_ready%0d: iresp.ready=%0b dresp.ready=%0b with nothing pending",
                                 k, ir[k].ready, dr[k].ready);
                    end else begin
                        e = q[k].pop_front();
                        chk($sformatf("owner_d%0d", k), 256'(dr[k].ready), 256'(e.is_d));
                        chk($sformatf("owner_i%0d", k), 256'(ir[k].ready), 256'(!e.is_d));
                        chk($sformatf("resp_data%0d", k), 256'(e.is_d ? dr[k].data : ir[k].data), 256'(e.data));
                        chk($sformatf("vreq%0d", k), 256'(cap[k]), 256'(e.req));
                    end
                end
                vprev[k] = v[k];
            end
        end
    end

    initial begin
        bit ok;
        ireq      = '0;
        dreq      = '0;
        mmu_ok    = 1'b0;
        mmu_presp = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        chk("reset_vreq0", 256'(vr[0]), 256'(0));
        chk("reset_vreq1", 256'(vr[1]), 256'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // Single instruction fetch
        ireq = mk(64'h8000_0000, 64'h0, 8'h00, 1'b0);
        expect_both(1'b0, 1'b0, 64'h13);
        serve(5, 64'h13, 1'b0);
        ireq = '0;
        repeat (3) @(posedge clk);

        // Ties from a fresh reset: round-robin alternates, D-priority keeps D
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        ireq = mk(64'h8000_0100, 64'h0, 8'h00, 1'b0);
        dreq = mk(64'h8000_0200, 64'h0, 8'h00, 1'b0);
        for (int n = 0; n < 4; n++) begin
            expect_both(n[0], 1'b1, 64'h100 + 64'(n));
            serve(n + 1, 64'h100 + 64'(n), 1'b0);
        end
        dreq = '0;
        expect_both(1'b0, 1'b0, 64'h200);
        serve(1, 64'h200, 1'b0);
        ireq = '0;
        repeat (3) @(posedge clk);

        // Data write while the instruction side churns underneath it
        #1 dreq = mk(64'h8000_1000, 64'hDEAD_BEEF, 8'hFF, 1'b1);
        expect_both(1'b1, 1'b1, 64'h55);
        serve(2, 64'h55, 1'b1);
        dreq = '0;
        repeat (3) @(posedge clk);

        // Reset while busy, then a stray completion pulse
        #1 ireq = mk(64'h8000_2000, 64'h0, 8'h00, 1'b0);
        wait_busy(ok);
        reset = 1'b1;
        ireq  = '0;
        @(negedge clk);
        check_quiet("abort_reset");
        @(posedge clk);
        #1 reset = 1'b0;
        mmu_ok    = 1'b1;
        mmu_presp = '{ready: 1'b1, data: 64'hFFFF_0000};
        @(posedge clk);
        #1 mmu_ok = 1'b0;
        mmu_presp = '0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_quiet("after_abort");
        end
        @(posedge clk);
        #1 ireq = mk(64'h8000_3000, 64'h0, 8'h00, 1'b0);
        expect_both(1'b0, 1'b0, 64'h77);
        serve(2, 64'h77, 1'b0);
        ireq = '0;
        repeat (5) @(posedge clk);

        @(negedge clk);
        chk("drained0", 256'(q[0].size()), 256'(0));
        chk("drained1", 256'(q[1].size()), 256'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
